// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module      : interrupt_controller_if
// Description : Device/core-side signal bundle for interrupt_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_controller_if #(
   parameter int NUM_IRQ = 16
);
   logic               clk_en;
   logic               halt;
   logic [NUM_IRQ-1:0] irq_raw;
   logic               mask_we;
   logic [NUM_IRQ-1:0] mask_wdata;
   logic               pend_clr_we;
   logic [NUM_IRQ-1:0] pend_clr_data;
   logic               interrupt_in_wb;
   logic [3:0]         ack_id;
   logic               rfi_in_wb;
   logic [NUM_IRQ-1:0] interrupts;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] in_service;
   logic [NUM_IRQ-1:0] mask;
   logic [7:0]         spurious_cnt;
   logic               busy;

   modport master (
      output clk_en, halt, irq_raw, mask_we, mask_wdata, pend_clr_we, pend_clr_data,
             interrupt_in_wb, ack_id, rfi_in_wb,
      input  interrupts, pending, in_service, mask, spurious_cnt, busy
   );

   modport slave (
      input  clk_en, halt, irq_raw, mask_we, mask_wdata, pend_clr_we, pend_clr_data,
             interrupt_in_wb, ack_id, rfi_in_wb,
      output interrupts, pending, in_service, mask, spurious_cnt, busy
   );
endinterface

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Synchronises device IRQs, latches edges as pending, masks and
//               gates them by in-service state; define IRQ_NESTING_EN for nesting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
   parameter int NUM_IRQ     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   interrupt_controller_if.slave irq_if
);
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_SERVICE = 1'b1
   } state_t;

   state_t                               state_q, state_d;
   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]  sync_q;
   logic [NUM_IRQ-1:0]                   hist_q;
   logic [NUM_IRQ-1:0]                   pending_q, pending_d;
   logic [NUM_IRQ-1:0]                   in_service_q, in_service_d;
   logic [NUM_IRQ-1:0]                   mask_q, mask_d;
   logic [NUM_IRQ-1:0]                   interrupts_q;
   logic [7:0]                           spur_q, spur_d;

   logic                                 w_advance;
   logic [NUM_IRQ-1:0]                   w_sync_out;
   logic [NUM_IRQ-1:0]                   w_rise;
   logic                                 w_ack_valid;
   logic [NUM_IRQ-1:0]                   w_ack_vec;
   logic [NUM_IRQ-1:0]                   w_rfi_clr;
   logic [NUM_IRQ-1:0]                   w_is_after_rfi;
   logic [NUM_IRQ-1:0]                   w_gate;
   logic                                 w_found;
   logic                                 w_seen;

   assign w_advance   = irq_if.clk_en & ~irq_if.halt;
   assign w_sync_out  = sync_q[SYNC_STAGES-1];
   assign w_rise      = w_sync_out & ~hist_q;
   assign w_ack_valid = 32'(irq_if.ack_id) < NUM_IRQ;
   assign w_ack_vec   = w_ack_valid ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_if.ack_id)
                                    : '0;

   // Highest in-service bit to retire on rfi, and the nesting priority gate.
   always_comb begin
      w_rfi_clr = '0;
      w_gate    = '0;
      w_found   = 1'b0;
      w_seen    = 1'b0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (in_service_q[i] && !w_found) begin
            w_rfi_clr[i] = 1'b1;
            w_found      = 1'b1;
         end
         w_seen    = w_seen | in_service_q[i];
         w_gate[i] = ~w_seen;
      end
`ifndef IRQ_NESTING_EN
      w_gate = (state_q == ST_IDLE) ? '1 : '0;
`endif
      w_is_after_rfi = irq_if.rfi_in_wb ? (in_service_q & ~w_rfi_clr) : in_service_q;
   end

   always_comb begin
      mask_d       = mask_q;
      in_service_d = in_service_q;
      spur_d       = spur_q;
      pending_d    = pending_q;
      if (irq_if.pend_clr_we) begin
         pending_d = pending_d & ~irq_if.pend_clr_data;
      end
      if (w_advance) begin
         if (irq_if.mask_we) begin
            mask_d = irq_if.mask_wdata;
         end
         in_service_d = w_is_after_rfi;
         if (irq_if.interrupt_in_wb) begin
            pending_d = pending_d & ~w_ack_vec;
`ifdef IRQ_NESTING_EN
            in_service_d = in_service_d | w_ack_vec;
`else
            if (w_is_after_rfi == '0) begin
               in_service_d = in_service_d | w_ack_vec;
            end
`endif
            if (((pending_q & w_ack_vec) == '0) && (spur_q != 8'hFF)) begin
               spur_d = spur_q + 8'd1;
            end
         end
      end
      // A new edge wins over any clear in the same cycle.
      pending_d = pending_d | w_rise;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (in_service_d != '0) state_d = ST_SERVICE;
         ST_SERVICE: if (in_service_d == '0) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sync_q       <= '0;
         hist_q       <= '0;
         pending_q    <= '0;
         in_service_q <= '0;
         mask_q       <= '0;
         interrupts_q <= '0;
         spur_q       <= '0;
      end else begin
         state_q      <= state_d;
         sync_q       <= {sync_q[SYNC_STAGES-2:0], irq_if.irq_raw};
         hist_q       <= w_sync_out;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         mask_q       <= mask_d;
         spur_q       <= spur_d;
         if (w_advance) begin
            interrupts_q <= pending_q & mask_q & w_gate;
         end
      end
   end

   assign irq_if.interrupts   = interrupts_q;
   assign irq_if.pending      = pending_q;
   assign irq_if.in_service   = in_service_q;
   assign irq_if.mask         = mask_q;
   assign irq_if.spurious_cnt = spur_q;
   assign irq_if.busy         = (state_q == ST_SERVICE);

endmodule

`default_nettype wire
